fifo4way16: RTL and testbench

FIFO4WAY16 -- requirements
Module: fifo4way16

---
 rtl/fifo4way16.sv | 86 ++++++++
 tb/tb_fifo4way16.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fifo4way16.sv
// Four-entry, 16-bit first-word-fall-through FIFO.
// The head entry is read through a 4-way select, and the overflow and underflow error flags stay set until reset.
module fifo4way16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [15:0] in,
  input  logic        push,
  input  logic        pop,
  output logic [15:0] out,
  output logic        empty,
  output logic        full,
  output logic [2:0]  count,
  output logic        overflow,
  output logic        underflow
);

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          empty_c, full_c;
  logic          push_acc_c, pop_acc_c;

  assign empty_c = (count_q == CW'(0));
  assign full_c  = (count_q == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a push into a full FIFO is still accepted when it is paired with a pop.
  assign pop_acc_c  = pop && !empty_c && !flush;
  assign push_acc_c = push && (!full_c || pop_acc_c) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_acc_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_acc_c) - CW'(pop_acc_c);
      if (push && !push_acc_c) ovf_d = 1'b1;
      if (pop && !pop_acc_c)   unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage has no reset; stale entries are never visible because the output is gated by empty.
  always_ff @(posedge clk) begin
    if (!reset && push_acc_c) mem_q[wr_ptr_q] <= in;
  end

  assign out       = empty_c ? DW'(0) : mem_q[rd_ptr_q];
  assign empty     = empty_c;
  assign full      = full_c;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fifo4way16.sv
// Directed self-checking bench for fifo4way16 with hand-computed expected values.
module tb_fifo4way16;

  logic        clk = 1'b0;
  logic        reset, flush, push, pop;
  logic [15:0] in;
  logic [15:0] out;
  logic        empty, full, overflow, underflow;
  logic [2:0]  count;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  fifo4way16 dut (
    .clk(clk), .reset(reset), .flush(flush), .in(in), .push(push), .pop(pop),
    .out(out), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic q, input logic [15:0] d);
    push = p;
    pop  = q;
    in   = d;
    step();
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [15:0] e_out, input logic [2:0] e_cnt,
                             input logic e_ovf, input logic e_unf);
    check({tag, ".out"}, out, e_out);
    check({tag, ".count"}, 16'(count), 16'(e_cnt));
    check({tag, ".empty"}, 16'(empty), 16'(e_cnt == 3'd0));
    check({tag, ".full"}, 16'(full), 16'(e_cnt == 3'd4));
    check({tag, ".ovf"}, 16'(overflow), 16'(e_ovf));
    check({tag, ".unf"}, 16'(underflow), 16'(e_unf));
  endtask

  initial begin
    logic [15:0] fill [4];
    logic [15:0] seq4 [4];
    fill = '{16'h1234, 16'h9876, 16'hAAAA, 16'h5555};
    seq4 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    reset = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; in = '0;
    step();
    step();
    reset = 1'b0;
    check_state("reset", 16'h0000, 3'd0, 1'b0, 1'b0);

    // First-word fall-through from empty
    drive(1'b1, 1'b0, 16'h1234);
    check_state("push1", 16'h1234, 3'd1, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) drive(1'b1, 1'b0, fill[i]);
    check_state("fill", 16'h1234, 3'd4, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 1'b1, '0);
      check("drain.out", out, fill[i]);
      check("drain.count", 16'(count), 16'(4 - i));
    end
    drive(1'b0, 1'b1, '0);
    check_state("drained", 16'h0000, 3'd0, 1'b0, 1'b0);

    // Overflow, then push+pop while full writes the wrapped slot
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, seq4[i]);
    check_state("refill", 16'h1111, 3'd4, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'hFFFF);
    check_state("ovf", 16'h1111, 3'd4, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 16'hBEEF);
    check_state("fullpp", 16'h2222, 3'd4, 1'b1, 1'b0);
    drive(1'b0, 1'b1, '0);
    check("pp.o1", out, 16'h3333);
    drive(1'b0, 1'b1, '0);
    check("pp.o2", out, 16'h4444);
    drive(1'b0, 1'b1, '0);
    check_state("wrapped", 16'hBEEF, 3'd1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, '0);
    check_state("empty2", 16'h0000, 3'd0, 1'b1, 1'b0);

    // Underflow, then push+pop on empty accepts only the push
    drive(1'b0, 1'b1, '0);
    check_state("unf", 16'h0000, 3'd0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 16'h00FF);
    check_state("emptypp", 16'h00FF, 3'd1, 1'b1, 1'b1);

    // Flush with a concurrent push
    drive(1'b1, 1'b0, 16'h00A1);
    drive(1'b1, 1'b0, 16'h00A2);
    check_state("three", 16'h00FF, 3'd3, 1'b1, 1'b1);
    flush = 1'b1;
    drive(1'b1, 1'b0, 16'hDEAD);
    flush = 1'b0;
    check_state("flush", 16'h0000, 3'd0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 16'h0777);
    check_state("postflush", 16'h0777, 3'd1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 16'h0888);

    // Streaming push+pop drives both pointers around the ring
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 16'h1000 + 16'(i));
      check("stream.out", out, (i == 0) ? 16'h0888 : 16'h1000 + 16'(i - 1));
      check("stream.count", 16'(count), 16'd2);
    end

    // Reset mid-stream with push asserted
    reset = 1'b1;
    drive(1'b1, 1'b1, 16'h4321);
    reset = 1'b0;
    check_state("midreset", 16'h0000, 3'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
